rbus_vo_cfg_master: RTL and testbench

- Ring-side event initiator that programs a remote rbus video-out box over the event channel.
- Emits the CMD_VGA_SET_* configuration sequence (0x20..0x28) and queued CMD_VGA_PUT_CHAR (0x26) events on the d2r_eve stb/ack interface.
- Sits in a controller/boot device; its d2r_eve outputs reach the display box's r2d_eve inputs through the ring.

---
 rtl/rbus_vo_pkg.sv | 56 +++++
 rtl/rbus_vo_char_fifo.sv | 56 +++++
 rtl/rbus_vo_cfg_master.sv | 168 ++++++++++++++++
 tb/tb_rbus_vo_cfg_master.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbus_vo_pkg.sv
// rbus_vo_pkg: definitions shared by the rbus video-out configuration master
// and the video-out box that receives its events.
//   - CMD_VGA_* event command codes (0x20..0x28)
//   - vo_state_t : master FSM state encoding
//   - vo_cfg_t   : snapshot of the configuration inputs
//   - cfg_event(): maps a configuration step index to {cmd, ptr}
package rbus_vo_pkg;

  localparam logic [7:0] CMD_VGA_SET_BASE_ADDR = 8'h20;
  localparam logic [7:0] CMD_VGA_SET_PH_WIDTH  = 8'h21;
  localparam logic [7:0] CMD_VGA_SET_LO_WIDTH  = 8'h22;
  localparam logic [7:0] CMD_VGA_SET_LO_HEIGHT = 8'h23;
  localparam logic [7:0] CMD_VGA_SET_MODE      = 8'h24;
  localparam logic [7:0] CMD_VGA_SET_TEXT_ENA  = 8'h25;
  localparam logic [7:0] CMD_VGA_PUT_CHAR      = 8'h26;
  localparam logic [7:0] CMD_VGA_SET_H_POL     = 8'h27;
  localparam logic [7:0] CMD_VGA_SET_V_POL     = 8'h28;

  localparam int CFG_SEQ_LEN = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_CHR  = 2'd2
  } vo_state_t;

  typedef struct packed {
    logic [38:0] base;
    logic [11:0] ph_width;
    logic [11:0] lo_width;
    logic [11:0] lo_height;
    logic [1:0]  mode;
    logic        h_pol;
    logic        v_pol;
    logic        text_ena;
  } vo_cfg_t;

  // Returns {cmd[7:0], ptr[39:0]} for step idx of the configuration sequence.
  // Unused payload bits are always zero.
  function automatic logic [47:0] cfg_event(input logic [2:0] idx, input vo_cfg_t c);
    logic [47:0] ev;
    ev = '0;
    case (idx)
      3'd0:    ev = {CMD_VGA_SET_BASE_ADDR, 1'b0, c.base};
      3'd1:    ev = {CMD_VGA_SET_PH_WIDTH, 28'd0, c.ph_width};
      3'd2:    ev = {CMD_VGA_SET_LO_WIDTH, 28'd0, c.lo_width};
      3'd3:    ev = {CMD_VGA_SET_LO_HEIGHT, 28'd0, c.lo_height};
      3'd4:    ev = {CMD_VGA_SET_MODE, 38'd0, c.mode};
      3'd5:    ev = {CMD_VGA_SET_H_POL, 39'd0, c.h_pol};
      3'd6:    ev = {CMD_VGA_SET_V_POL, 39'd0, c.v_pol};
      default: ev = {CMD_VGA_SET_TEXT_ENA, 39'd0, c.text_ena};
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/rbus_vo_char_fifo.sv
// rbus_vo_char_fifo: synchronous FIFO for queued characters.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (empties the FIFO)
//   wr_en, wr_dat  write request; ignored while full
//   rd_en          pop request; ignored while empty
//   rd_dat         current head (valid while count != 0)
//   full           count == DEPTH
//   count          number of stored entries, 0..DEPTH
module rbus_vo_char_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_dat,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_dat,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full   = (count == (AW+1)'(DEPTH));
  // Fullness is judged on the current count, so a pop in the same cycle does
  // not make room for a write.
  assign wr_ok  = wr_en && !full;
  assign rd_ok  = rd_en && (count != '0);
  assign rd_dat = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (!wr_ok && rd_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/rbus_vo_cfg_master.sv
// rbus_vo_cfg_master: drives the d2r_eve event channel toward a remote rbus
// video-out box. Sends the 8-event CMD_VGA_SET_* configuration sequence on
// cfg_start and otherwise drains queued characters as CMD_VGA_PUT_CHAR.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_start, cfg_*    configuration request and values (sampled on accept)
//   chr_stb, chr_dat    character write; chr_full / chr_ovf (sticky) status
//   busy, done          sequence in progress or pending / completion pulse
//   d2r_eve_*           event channel; valid/ready handshake:
//                       a transfer happens on any cycle with stb && ack; while
//                       stb && !ack the cmd/ptr outputs hold; ack may be a
//                       combinational function of stb.
//   dbg_state           current FSM state (vo_state_t encoding)
module rbus_vo_cfg_master
  import rbus_vo_pkg::*;
#(
  parameter logic [7:0] DEV_ID          = 8'h00,
  parameter int         CHAR_FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [38:0] cfg_base_addr,
  input  logic [11:0] cfg_ph_width,
  input  logic [11:0] cfg_lo_width,
  input  logic [11:0] cfg_lo_height,
  input  logic [1:0]  cfg_mode,
  input  logic        cfg_h_pol,
  input  logic        cfg_v_pol,
  input  logic        cfg_text_ena,
  input  logic        chr_stb,
  input  logic [7:0]  chr_dat,
  output logic        chr_full,
  output logic        chr_ovf,
  output logic        busy,
  output logic        done,
  output logic        d2r_eve_stb,
  output logic [7:0]  d2r_eve_cmd,
  output logic [7:0]  d2r_eve_dev,
  output logic [39:0] d2r_eve_ptr,
  input  logic        d2r_eve_ack,
  output logic [1:0]  dbg_state
);

  vo_state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  vo_cfg_t    shadow_q, shadow_d;
  vo_cfg_t    cfg_in;
  logic       pend_q, pend_d;
  logic       done_d;
  logic       start_req;
  logic       xfer;
  logic       pop;
  logic [7:0] fifo_head;
  logic       fifo_empty;
  logic [$clog2(CHAR_FIFO_DEPTH):0] fifo_count;
  logic        stb_d;
  logic [7:0]  cmd_d;
  logic [39:0] ptr_d;

  assign cfg_in = '{base: cfg_base_addr, ph_width: cfg_ph_width,
                    lo_width: cfg_lo_width, lo_height: cfg_lo_height,
                    mode: cfg_mode, h_pol: cfg_h_pol, v_pol: cfg_v_pol,
                    text_ena: cfg_text_ena};

  assign start_req   = cfg_start || pend_q;
  assign xfer        = d2r_eve_stb && d2r_eve_ack;
  assign pop         = (state_q == ST_CHR) && xfer;
  assign fifo_empty  = (fifo_count == '0);
  assign d2r_eve_dev = DEV_ID;
  assign busy        = (state_q == ST_CFG) || pend_q;
  assign dbg_state   = state_q;

  rbus_vo_char_fifo #(.DEPTH(CHAR_FIFO_DEPTH), .W(8)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (chr_stb),
    .wr_dat (chr_dat),
    .rd_en  (pop),
    .rd_dat (fifo_head),
    .full   (chr_full),
    .count  (fifo_count)
  );

  // State register plus the registered event outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shadow_q    <= '0;
      pend_q      <= 1'b0;
      done        <= 1'b0;
      chr_ovf     <= 1'b0;
      d2r_eve_stb <= 1'b0;
      d2r_eve_cmd <= '0;
      d2r_eve_ptr <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      done        <= done_d;
      if (chr_stb && chr_full) chr_ovf <= 1'b1;
      d2r_eve_stb <= stb_d;
      d2r_eve_cmd <= cmd_d;
      d2r_eve_ptr <= ptr_d;
    end
  end

  // Next-state logic. Configuration wins over characters in IDLE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          shadow_d = cfg_in;
          idx_d    = '0;
          pend_d   = 1'b0;
          state_d  = ST_CFG;
        end else if (!fifo_empty) begin
          state_d = ST_CHR;
        end
      end
      ST_CFG: begin
        if (cfg_start) pend_d = 1'b1;
        if (xfer) begin
          if (idx_q == 3'(CFG_SEQ_LEN - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_CHR: begin
        if (cfg_start) pend_d = 1'b1;
        if (xfer) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: the event to present next cycle, derived from the next
  // state so that outputs are registered yet appear right after acceptance.
  // With no ack, idx/shadow/FIFO head are unchanged, so cmd/ptr hold.
  always_comb begin
    stb_d = 1'b0;
    cmd_d = '0;
    ptr_d = '0;
    case (state_d)
      ST_CFG: begin
        stb_d          = 1'b1;
        {cmd_d, ptr_d} = cfg_event(idx_d, shadow_d);
      end
      ST_CHR: begin
        stb_d = 1'b1;
        cmd_d = CMD_VGA_PUT_CHAR;
        ptr_d = {32'd0, fifo_head};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rbus_vo_cfg_master.sv
module tb_rbus_vo_cfg_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [38:0] cfg_base_addr = '0;
  logic [11:0] cfg_ph_width = '0;
  logic [11:0] cfg_lo_width = '0;
  logic [11:0] cfg_lo_height = '0;
  logic [1:0]  cfg_mode = '0;
  logic        cfg_h_pol = 1'b0;
  logic        cfg_v_pol = 1'b0;
  logic        cfg_text_ena = 1'b0;
  logic        chr_stb = 1'b0;
  logic [7:0]  chr_dat = '0;
  logic        chr_full;
  logic        chr_ovf;
  logic        busy;
  logic        done;
  logic        d2r_eve_stb;
  logic [7:0]  d2r_eve_cmd;
  logic [7:0]  d2r_eve_dev;
  logic [39:0] d2r_eve_ptr;
  logic        d2r_eve_ack = 1'b0;
  logic [1:0]  dbg_state;

  rbus_vo_cfg_master #(.DEV_ID(8'h00), .CHAR_FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_base_addr(cfg_base_addr), .cfg_ph_width(cfg_ph_width),
    .cfg_lo_width(cfg_lo_width), .cfg_lo_height(cfg_lo_height),
    .cfg_mode(cfg_mode), .cfg_h_pol(cfg_h_pol), .cfg_v_pol(cfg_v_pol),
    .cfg_text_ena(cfg_text_ena), .chr_stb(chr_stb), .chr_dat(chr_dat),
    .chr_full(chr_full), .chr_ovf(chr_ovf), .busy(busy), .done(done),
    .d2r_eve_stb(d2r_eve_stb), .d2r_eve_cmd(d2r_eve_cmd),
    .d2r_eve_dev(d2r_eve_dev), .d2r_eve_ptr(d2r_eve_ptr),
    .d2r_eve_ack(d2r_eve_ack), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  logic [47:0] exp_q[$];
  logic [47:0] got_q[$];
  int          got_cyc[$];
  int          done_cyc[$];

  bit          ack_en = 1'b1;
  int          hold_left = 0;
  logic [7:0]  hold_cmd = 8'hff;
  logic [39:0] hold_ptr = '0;
  int          n_hold_seen = 0;
  int          n_hold_stable = 0;
  bit          busy_watch = 1'b0;
  int          busy_drops = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample 1ns after the rising edge, then drive ack for this cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    d2r_eve_ack = 1'b0;
    if (d2r_eve_stb) begin
      if (d2r_eve_cmd == hold_cmd) begin
        n_hold_seen++;
        if (d2r_eve_ptr == hold_ptr) n_hold_stable++;
      end
      if (hold_left > 0 && d2r_eve_cmd == hold_cmd) hold_left--;
      else if (ack_en) d2r_eve_ack = 1'b1;
    end
    if (d2r_eve_stb && d2r_eve_ack) begin
      got_q.push_back({d2r_eve_cmd, d2r_eve_ptr});
      got_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (busy_watch && !busy) busy_drops++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_cfg();
    cfg_start = 1'b1;
    t0 = cyc;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic set_cfg(input logic [38:0] b, input logic [11:0] ph, input logic [11:0] lw,
                         input logic [11:0] lh, input logic [1:0] m, input logic hp,
                         input logic vp, input logic te);
    cfg_base_addr = b; cfg_ph_width = ph; cfg_lo_width = lw; cfg_lo_height = lh;
    cfg_mode = m; cfg_h_pol = hp; cfg_v_pol = vp; cfg_text_ena = te;
  endtask

  // Expected wire order of the configuration sequence.
  task automatic push_cfg(input logic [38:0] b, input logic [11:0] ph, input logic [11:0] lw,
                          input logic [11:0] lh, input logic [1:0] m, input logic hp,
                          input logic vp, input logic te);
    exp_q.push_back({8'h20, 1'b0, b});
    exp_q.push_back({8'h21, 28'd0, ph});
    exp_q.push_back({8'h22, 28'd0, lw});
    exp_q.push_back({8'h23, 28'd0, lh});
    exp_q.push_back({8'h24, 38'd0, m});
    exp_q.push_back({8'h27, 39'd0, hp});
    exp_q.push_back({8'h28, 39'd0, vp});
    exp_q.push_back({8'h25, 39'd0, te});
  endtask

  task automatic compare_events(input string tag);
    logic [47:0] g;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 48'hdead_dead_dead;
      check($sformatf("%s_ev%0d", tag, i), g, exp_q[i]);
    end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    done_cyc.delete();
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #3;
    check("rst_stb", d2r_eve_stb, 0);
    check("rst_cmd", d2r_eve_cmd, 0);
    check("rst_ptr", d2r_eve_ptr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", chr_ovf, 0);
    check("rst_full", chr_full, 0);
    check("dev_id", d2r_eve_dev, 8'h00);
    rst = 1'b0;
    run(2);

    // Full sequence, ack follows stb
    set_cfg(39'h1_0000_0200, 12'd2048, 12'd480, 12'd272, 2'd2, 1'b1, 1'b0, 1'b1);
    start_cfg();
    check("seq_busy", busy, 1);
    run(11);
    check("seq_first_cyc", q_at(got_cyc, 0), t0 + 1);
    check("seq_last_cyc", q_at(got_cyc, 7), t0 + 8);
    check("seq_done_n", done_cyc.size(), 1);
    check("seq_done_cyc", q_at(done_cyc, 0), t0 + 9);
    check("seq_busy_end", busy, 0);
    push_cfg(39'h1_0000_0200, 12'd2048, 12'd480, 12'd272, 2'd2, 1'b1, 1'b0, 1'b1);
    compare_events("seq");

    // Back-pressure on idx 3 (lo_height)
    hold_cmd = 8'h23; hold_ptr = 40'd272; hold_left = 5;
    n_hold_seen = 0; n_hold_stable = 0;
    start_cfg();
    run(16);
    check("bp_held_cycles", n_hold_seen, 6);
    check("bp_stable_cycles", n_hold_stable, 6);
    check("bp_done_cyc", q_at(done_cyc, 0), t0 + 14);
    hold_cmd = 8'hff;
    push_cfg(39'h1_0000_0200, 12'd2048, 12'd480, 12'd272, 2'd2, 1'b1, 1'b0, 1'b1);
    compare_events("bp");

    // Characters A, B, C while idle
    chr_stb = 1'b1; chr_dat = 8'h41; tick();
    chr_dat = 8'h42; tick();
    chr_dat = 8'h43; tick();
    chr_stb = 1'b0;
    run(10);
    check("chr_gap_ab", q_at(got_cyc, 1) - q_at(got_cyc, 0), 2);
    check("chr_gap_bc", q_at(got_cyc, 2) - q_at(got_cyc, 1), 2);
    exp_q.push_back({8'h26, 40'h41});
    exp_q.push_back({8'h26, 40'h42});
    exp_q.push_back({8'h26, 40'h43});
    compare_events("abc");
    check("abc_ovf", chr_ovf, 0);

    // 17 writes with ack low: full after 16, 17th dropped
    ack_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chr_stb = 1'b1;
      chr_dat = 8'h60 + 8'(i);
      tick();
      if (i == 14) check("fill_not_full_15", chr_full, 0);
      if (i == 15) begin
        check("fill_full_16", chr_full, 1);
        check("fill_ovf_16", chr_ovf, 0);
      end
    end
    chr_stb = 1'b0;
    check("fill_ovf_17", chr_ovf, 1);
    check("fill_no_xfer", got_q.size(), 0);
    ack_en = 1'b1;
    run(40);
    check("drain_full", chr_full, 0);
    check("drain_ovf_sticky", chr_ovf, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back({8'h26, 32'd0, 8'h60 + 8'(i)});
    compare_events("drain");

    // Restart request during idx 4 with new lo_width
    busy_watch = 1'b1; busy_drops = 0;
    start_cfg();
    run(3);
    cfg_lo_width = 12'd320;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run(12);
    busy_watch = 1'b0;
    run(3);
    check("rs_busy_drops", busy_drops, 0);
    check("rs_done_n", done_cyc.size(), 2);
    check("rs_done0", q_at(done_cyc, 0), t0 + 9);
    check("rs_done1", q_at(done_cyc, 1), t0 + 18);
    push_cfg(39'h1_0000_0200, 12'd2048, 12'd480, 12'd272, 2'd2, 1'b1, 1'b0, 1'b1);
    push_cfg(39'h1_0000_0200, 12'd2048, 12'd320, 12'd272, 2'd2, 1'b1, 1'b0, 1'b1);
    compare_events("rs");

    // Reset at idx 5 with stb high and ack low
    start_cfg();
    run(4);
    ack_en = 1'b0;
    tick();
    check("mr_stb_pre", d2r_eve_stb, 1);
    check("mr_cmd_pre", d2r_eve_cmd, 8'h27);
    #2 rst = 1'b1;
    #1;
    check("mr_stb", d2r_eve_stb, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_ovf", chr_ovf, 0);
    check("mr_full", chr_full, 0);
    #3 rst = 1'b0;
    got_q.delete(); got_cyc.delete(); done_cyc.delete();
    ack_en = 1'b1;
    run(10);
    check("mr_no_events", got_q.size(), 0);
    check("mr_busy_after", busy, 0);
    check("mr_done_after", done_cyc.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Overall time bound
  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
